// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: micro-op kind encodings and
// default latency parameters.
`timescale 1ns/1ps
package reg_scoreboard_pkg;

  typedef enum logic [1:0] {
    UOP_ALU = 2'b00,
    UOP_MUL = 2'b01,
    UOP_MEM = 2'b10,
    UOP_DIV = 2'b11
  } uop_kind_e;

  localparam int MUL_LAT_DEF = 2;
  localparam int CNT_W_DEF   = 2;

  // ALU results are always forwardable in time, so only the other kinds are tracked.
  function automatic logic is_tracked(input logic [1:0] kind);
    return kind != UOP_ALU;
  endfunction

endpackage

// File: rtl/reg_scoreboard_entry.sv
// One register's scoreboard entry: idle, fixed-latency countdown (mul) or
// waiting for a writeback (mem/div).
`timescale 1ns/1ps
module reg_scoreboard_entry #(
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic flush,
  input  logic pipe_stall,
  input  logic issue_hit,
  input  logic issue_var,
  input  logic wb_hit,
  output logic pending
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIXED,
    ST_VAR
  } entry_state_e;

  entry_state_e     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (flush) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else if (issue_hit) begin
      // A new producer overrides whatever the old one was doing.
      if (issue_var) begin
        state_next = ST_VAR;
        cnt_next   = '0;
      end else begin
        state_next = ST_FIXED;
        cnt_next   = CNT_W'(MUL_LAT);
      end
    end else begin
      case (state_reg)
        ST_FIXED: begin
          if (!pipe_stall) begin
            if (cnt_reg <= CNT_W'(1)) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg - CNT_W'(1);
            end
          end
        end
        ST_VAR: begin
          if (wb_hit) state_next = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign pending = (state_reg != ST_IDLE);

endmodule

// File: rtl/reg_scoreboard.sv
// Tracks destination registers of in-flight mul/mem/div producers and raises
// a combinational stall for rf-stage operands that are not yet forwardable.
`timescale 1ns/1ps
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        pipe_stall,
  input  logic        eu0_issue_en,
  input  logic [4:0]  eu0_issue_rd,
  input  logic [1:0]  eu0_issue_kind,
  input  logic        eu1_issue_en,
  input  logic        eu0_en_in,
  input  logic [4:0]  eu0_rj,
  input  logic [4:0]  eu0_rk,
  input  logic [4:0]  eu0_rd,
  input  logic        eu1_en_in,
  input  logic [4:0]  eu1_rj,
  input  logic [4:0]  eu1_rk,
  input  logic [4:0]  eu1_rd,
  input  logic        wb0_en,
  input  logic [4:0]  wb0_rd,
  input  logic        wb1_en,
  input  logic [4:0]  wb1_rd,
  output logic        stall_req,
  output logic [31:0] busy_mask
);

  logic [31:0] pending_vec;
  logic        issue_ok;
  logic        issue_var;
  logic        intra_raw;

  // eu1 only issues ALU ops, which never need tracking.
  logic unused_eu1_issue;
  assign unused_eu1_issue = eu1_issue_en;

  assign issue_ok  = eu0_issue_en && !pipe_stall && !flush && is_tracked(eu0_issue_kind);
  assign issue_var = (eu0_issue_kind != UOP_MUL);

  assign pending_vec[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_entry
      logic issue_hit;
      logic wb_hit;

      assign issue_hit = issue_ok && (eu0_issue_rd == 5'(gi));
      assign wb_hit    = (wb0_en && (wb0_rd == 5'(gi))) || (wb1_en && (wb1_rd == 5'(gi)));

      reg_scoreboard_entry #(
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W)
      ) u_entry (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .pipe_stall (pipe_stall),
        .issue_hit  (issue_hit),
        .issue_var  (issue_var),
        .wb_hit     (wb_hit),
        .pending    (pending_vec[gi])
      );
    end
  endgenerate

  // eu1 reading the destination of a tracked eu0 op in the same pair must wait too.
  assign intra_raw = eu0_en_in && eu1_en_in && is_tracked(eu0_issue_kind) &&
                     (eu0_rd != 5'd0) && ((eu1_rj == eu0_rd) || (eu1_rk == eu0_rd));

  always_comb begin
    stall_req = intra_raw;
    if (eu0_en_in && (pending_vec[eu0_rj] || pending_vec[eu0_rk] || pending_vec[eu0_rd]))
      stall_req = 1'b1;
    if (eu1_en_in && (pending_vec[eu1_rj] || pending_vec[eu1_rk] || pending_vec[eu1_rd]))
      stall_req = 1'b1;
  end

  assign busy_mask = pending_vec;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed and randomized checks of reg_scoreboard against a per-register
// pending/latency model built from the scoreboard rules.
`timescale 1ns/1ps
module tb_reg_scoreboard;

  logic        clk;
  logic        rstn;
  logic        flush, pipe_stall;
  logic        eu0_issue_en, eu1_issue_en;
  logic [4:0]  eu0_issue_rd;
  logic [1:0]  eu0_issue_kind;
  logic        eu0_en_in, eu1_en_in;
  logic [4:0]  eu0_rj, eu0_rk, eu0_rd;
  logic [4:0]  eu1_rj, eu1_rk, eu1_rd;
  logic        wb0_en, wb1_en;
  logic [4:0]  wb0_rd, wb1_rd;
  logic        stall_req;
  logic [31:0] busy_mask;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pending flag, variable-latency flag, remaining unstalled cycles.
  bit m_p [32];
  bit m_v [32];
  int m_cnt [32];

  reg_scoreboard dut (
    .clk            (clk),
    .rstn           (rstn),
    .flush          (flush),
    .pipe_stall     (pipe_stall),
    .eu0_issue_en   (eu0_issue_en),
    .eu0_issue_rd   (eu0_issue_rd),
    .eu0_issue_kind (eu0_issue_kind),
    .eu1_issue_en   (eu1_issue_en),
    .eu0_en_in      (eu0_en_in),
    .eu0_rj         (eu0_rj),
    .eu0_rk         (eu0_rk),
    .eu0_rd         (eu0_rd),
    .eu1_en_in      (eu1_en_in),
    .eu1_rj         (eu1_rj),
    .eu1_rk         (eu1_rk),
    .eu1_rd         (eu1_rd),
    .wb0_en         (wb0_en),
    .wb0_rd         (wb0_rd),
    .wb1_en         (wb1_en),
    .wb1_rd         (wb1_rd),
    .stall_req      (stall_req),
    .busy_mask      (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    for (int r = 1; r < 32; r++) m[r] = m_p[r];
    return m;
  endfunction

  function automatic logic model_stall();
    logic s;
    s = 1'b0;
    if (eu0_en_in) s = s | m_p[eu0_rj] | m_p[eu0_rk] | m_p[eu0_rd];
    if (eu1_en_in) s = s | m_p[eu1_rj] | m_p[eu1_rk] | m_p[eu1_rd];
    if (eu0_en_in && eu1_en_in && eu0_issue_kind != 2'b00 && eu0_rd != 5'd0 &&
        (eu1_rj == eu0_rd || eu1_rk == eu0_rd)) s = 1'b1;
    return s;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_p[r] = 0; m_v[r] = 0; m_cnt[r] = 0;
    end
  endtask

  task automatic model_tick();
    if (flush) begin
      model_reset();
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (m_p[r] && m_v[r] &&
            ((wb0_en && wb0_rd == 5'(r)) || (wb1_en && wb1_rd == 5'(r)))) begin
          m_p[r] = 0;
        end else if (!pipe_stall && m_p[r] && !m_v[r] && m_cnt[r] != 0) begin
          m_cnt[r] = m_cnt[r] - 1;
          if (m_cnt[r] == 0) m_p[r] = 0;
        end
      end
      if (eu0_issue_en && !pipe_stall && eu0_issue_rd != 5'd0 && eu0_issue_kind != 2'b00) begin
        m_p[eu0_issue_rd] = 1;
        m_v[eu0_issue_rd] = (eu0_issue_kind != 2'b01);
        m_cnt[eu0_issue_rd] = (eu0_issue_kind == 2'b01) ? 2 : 0;
      end
    end
  endtask

  task automatic idle();
    flush = 0; pipe_stall = 0;
    eu0_issue_en = 0; eu0_issue_rd = 0; eu0_issue_kind = 0; eu1_issue_en = 0;
    eu0_en_in = 0; eu0_rj = 0; eu0_rk = 0; eu0_rd = 0;
    eu1_en_in = 0; eu1_rj = 0; eu1_rk = 0; eu1_rd = 0;
    wb0_en = 0; wb0_rd = 0; wb1_en = 0; wb1_rd = 0;
  endtask

  // Called 1ns after a rising edge with inputs already driven; returns 1ns after the next edge.
  task automatic cycle(input int exp_stall = -1);
    #1;
    chk("stall_model", {31'd0, stall_req}, {31'd0, model_stall()});
    chk("busy_model", busy_mask, model_mask());
    if (exp_stall >= 0) chk("stall_directed", {31'd0, stall_req}, exp_stall);
    $display("cyc t=%0t iss=%b k=%0d rd=%0d fl=%b ps=%b stall=%b busy=%h",
             $time, eu0_issue_en, eu0_issue_kind, eu0_issue_rd, flush, pipe_stall,
             stall_req, busy_mask);
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic issue(input logic [1:0] kind, input logic [4:0] rd);
    idle();
    eu0_issue_en = 1; eu0_issue_kind = kind; eu0_issue_rd = rd;
    cycle();
    idle();
  endtask

  logic [31:0] saved_mask;

  initial begin
    idle();
    model_reset();
    rstn = 0;
    #2;
    chk("reset_busy", busy_mask, 32'd0);
    chk("reset_stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #1;
    rstn = 1;
    cycle(0);

    // mul r5 then dependent read: stall 2 cycles, clear on the third
    issue(2'b01, 5'd5);
    eu0_en_in = 1; eu0_rj = 5;
    cycle(1); cycle(1); cycle(0);
    idle();

    // load r7 consumed by eu1 rk: stalls until the cycle after wb0
    issue(2'b10, 5'd7);
    eu1_en_in = 1; eu1_rk = 7;
    cycle(1); cycle(1); cycle(1);
    wb0_en = 1; wb0_rd = 7;
    cycle(1);
    wb0_en = 0;
    cycle(0);
    idle();

    // mul r3 frozen by pipe_stall for 4 cycles
    issue(2'b01, 5'd3);
    pipe_stall = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("mul_frozen", {31'd0, busy_mask[3]}, 32'd1);
    end
    pipe_stall = 0;
    cycle();
    chk("mul_unstall1", {31'd0, busy_mask[3]}, 32'd1);
    cycle();
    chk("mul_unstall2", {31'd0, busy_mask[3]}, 32'd0);

    // div r9 flushed; late wb1 ignored
    issue(2'b11, 5'd9);
    chk("div_pending", {31'd0, busy_mask[9]}, 32'd1);
    flush = 1; eu0_issue_en = 1; eu0_issue_kind = 2'b01; eu0_issue_rd = 5'd12;
    cycle();
    chk("flush_clear", busy_mask, 32'd0);
    idle();
    wb1_en = 1; wb1_rd = 9;
    cycle();
    chk("late_wb", busy_mask, 32'd0);

    // re-issue mem r4 while an old wb0 to r4 arrives: issue wins
    issue(2'b10, 5'd4);
    eu0_issue_en = 1; eu0_issue_kind = 2'b10; eu0_issue_rd = 4;
    wb0_en = 1; wb0_rd = 4;
    cycle();
    chk("issue_over_wb", {31'd0, busy_mask[4]}, 32'd1);
    idle();
    wb0_en = 1; wb0_rd = 4;
    cycle();
    chk("wb_retire", {31'd0, busy_mask[4]}, 32'd0);

    // r0 never stalls and is never tracked
    issue(2'b11, 5'd2);
    saved_mask = busy_mask;
    eu0_en_in = 1; eu1_en_in = 1;
    eu0_issue_en = 1; eu0_issue_kind = 2'b01; eu0_issue_rd = 0;
    cycle(0);
    chk("r0_issue", busy_mask, saved_mask);
    idle();
    wb1_en = 1; wb1_rd = 2;
    cycle();

    // async reset in the middle of a mul countdown
    issue(2'b01, 5'd6);
    #3 rstn = 0;
    #1;
    chk("async_reset", busy_mask, 32'd0);
    model_reset();
    #2 rstn = 1;
    eu0_en_in = 1; eu0_rj = 6;
    #1;
    chk("post_reset_stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk); model_tick(); #1;
    cycle(0);

    // randomized traffic on a small register window to get frequent hits
    for (int i = 0; i < 400; i++) begin
      flush          = ($urandom_range(31) == 0);
      pipe_stall     = ($urandom_range(4) == 0);
      eu0_issue_en   = $urandom_range(1);
      eu0_issue_kind = 2'($urandom_range(3));
      eu0_issue_rd   = 5'($urandom_range(7));
      eu1_issue_en   = $urandom_range(1);
      eu0_en_in      = $urandom_range(1);
      eu0_rj         = 5'($urandom_range(7));
      eu0_rk         = 5'($urandom_range(7));
      eu0_rd         = 5'($urandom_range(7));
      eu1_en_in      = $urandom_range(1);
      eu1_rj         = 5'($urandom_range(7));
      eu1_rk         = 5'($urandom_range(7));
      eu1_rd         = 5'($urandom_range(7));
      wb0_en         = $urandom_range(1);
      wb0_rd         = 5'($urandom_range(7));
      wb1_en         = $urandom_range(1);
      wb1_rd         = 5'($urandom_range(7));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
